// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// Frame: header byte, all register bytes MSB-first, optional XOR byte (REGDUMP_TX_CHECKSUM_EN).
package regdump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam int          NUM_REGS_DEFAULT = 32;
    localparam int          REG_W_DEFAULT    = 32;
    localparam logic [7:0]  HEADER_DEFAULT   = 8'hA5;
    localparam int          BYTES_PER_FRAME  = NUM_REGS_DEFAULT * REG_W_DEFAULT / 8;

    function automatic int frame_bytes(input int num_regs, input int reg_w);
        return num_regs * reg_w / 8;
    endfunction

endpackage

// File: rtl/regdump_tx_if.sv
// Byte stream valid/ready link from the dump transmitter to the debug host path.
interface regdump_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/regdump_tx.sv
// Snapshots the flat register bus on start and streams it out as a byte frame.
// Build option REGDUMP_TX_CHECKSUM_EN appends an XOR byte of all data bytes.
//
// state | meaning
// IDLE  | waiting for start; tx_valid low, busy low
// HDR   | offering the header byte
// DATA  | offering snapshot byte idx_q
// CHK   | offering the XOR of all data bytes (checksum build only)
module regdump_tx
    import regdump_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEFAULT,
    parameter int         REG_W    = REG_W_DEFAULT,
    parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [NUM_REGS*REG_W-1:0] regs,
    regdump_tx_if.master              tx,
    output logic                      busy,
    output logic                      done
);

    localparam int BYTES = frame_bytes(NUM_REGS, REG_W);
    localparam int BPR   = REG_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             capture;
    logic             done_d;

    // Snapshot is stored already in transmit order so DATA is a plain index.
    logic [7:0]       snap_q [BYTES];

`ifdef REGDUMP_TX_CHECKSUM_EN
    logic [7:0]       chk_q;
    logic [7:0]       chk_d;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        done_d      = 1'b0;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
`ifdef REGDUMP_TX_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    idx_d   = '0;
`ifdef REGDUMP_TX_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = HDR;
                end
            end
            HDR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HEADER;
                if (tx.tx_ready) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = snap_q[idx_q];
                if (tx.tx_ready) begin
`ifdef REGDUMP_TX_CHECKSUM_EN
                    chk_d = chk_q ^ snap_q[idx_q];
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_TX_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef REGDUMP_TX_CHECKSUM_EN
            CHK: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = chk_q;
                if (tx.tx_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done    <= 1'b0;
`ifdef REGDUMP_TX_CHECKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done    <= done_d;
`ifdef REGDUMP_TX_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Register r lands at byte slots r*BPR .. r*BPR+BPR-1, most-significant byte first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BYTES; i++) begin
                snap_q[i] <= 8'h00;
            end
        end else if (capture) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int b = 0; b < BPR; b++) begin
                    snap_q[r*BPR + b] <= regs[REG_W*r + 8*(BPR-1-b) +: 8];
                end
            end
        end
    end

endmodule
